uart_rx_param: RTL
==================

# uart_rx_param

Parametrised UART receiver for the serial RX path. It sits between the baud-rate generator (`s_tick`) and the byte consumer. It supports 5–9 data bits, optional even/odd parity, 1 or 2 stop bits, a configurable oversampling factor and 3-sample majority voting. It also provides false-start rejection and reports parity, framing and break conditions alongside each received word.

## Interface
- `DBIT`, 8, data bits per frame, legal 5..9, sent LSB first
- `OVERSAMPLE`, 16, `s_tick` pulses per bit period; even, ≥ 8
- `PARITY_EN`, 0, 1 = a parity bit follows the data bits
- `PARITY_ODD`, 0, parity sense when `PARITY_EN` = 1 (0 = even, 1 = odd)
- `STOP_BITS`, 1, number of stop bits checked, 1 or 2
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low.
- `s_tick` in 1: one-`clk` pulse, `OVERSAMPLE` per bit.
- `rx` in 1: asynchronous serial line, idles high.
- `dout` out DBIT: last received word, held until the next frame completes.
- `rx_done_tick` out 1: one-cycle pulse; `dout` and flags are valid with it.
- `parity_err` out 1: parity mismatch for the frame in `dout`; always 0 if `PARITY_EN` = 0.
- `frame_err` out 1: a stop bit was sampled low.
- `break_det` out 1: all data, parity and stop samples were 0.
- `busy` out 1: high in every state except IDLE.

## Operation
- **Input synchroniser**
  - `rx` passes through a 2-flop synchroniser; both flops reset to 1.
  - All logic uses the synchronised `rx_s`.
- **Sampling and counters**
  - Tick counter `s` counts `s_tick` within a bit, 0..OVERSAMPLE-1, then wraps to 0.
  - Bit counter `n` counts 0..DBIT-1.
  - Let H = OVERSAMPLE/2. `rx_s` is sampled on the ticks where `s` = H-1, H, H+1.
  - The bit value is the majority of these three samples.
- **State machine:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE**
    - On `rx_s` = 0 (any `clk`, no tick needed): clear `s`, `n` and the shift register, then go to START.
  - **START**
    - On the tick where `s` = H+1, resolve the majority.
    - Majority 1: false start, return to IDLE with no pulse and no flag change.
    - Majority 0: continue counting. At `s` = OVERSAMPLE-1, wrap `s` and go to DATA.
  - **DATA**
    - The majority bit shifts in at the MSB side: shift right, `b[DBIT-1]` = bit.
    - At `s` = OVERSAMPLE-1 with `n` = DBIT-1, go to PARITY if `PARITY_EN`, else STOP.
    - Otherwise at `s` = OVERSAMPLE-1, increment `n`.
  - **PARITY**
    - Compare the majority bit with XOR(data) XOR `PARITY_ODD`; store the mismatch.
    - Go to STOP at `s` = OVERSAMPLE-1.
  - **STOP**
    - Each stop bit's majority is recorded.
    - With `STOP_BITS` = 2, the first stop bit spans a full period and the second is sampled the same way.
    - On the tick where `s` = H+1 of the last stop bit, complete the frame:
      - load `dout` and the flags;
      - pulse `rx_done_tick`;
      - go to IDLE.
    - This allows back-to-back frames with no idle gap.
- **Flags**
  - `frame_err` = any stop bit sampled 0.
  - `break_det` = data = 0, parity sample 0 (if present) and all stop samples 0; `frame_err` is also 1 in this case.
  - All flags update only on frame completion.
- **Line held low after a break:** after IDLE, a new START begins immediately. The false-start logic does not trigger, so a frame is reported once per frame length while the line stays low.

## Timing
- **Reset values**
  - `dout` = 0; `rx_done_tick`, `parity_err`, `frame_err`, `break_det`, `busy` = 0.
  - State IDLE; counters 0.
  - Reset asserted mid-frame aborts the frame with no pulse. Receiving resumes at the first falling edge after release.
- **Input latency:** 2 `clk` from a pin edge to `rx_s`.
- **Frame completion:** `rx_done_tick` is registered, high for exactly 1 `clk`, on the cycle after the completing `s_tick`. `dout` and the flags change on that same edge.
- **Frame length:** start to done = OVERSAMPLE·(1 + DBIT + PARITY_EN + STOP_BITS − 1) + H + 2 ticks, ±1 tick for edge alignment.
- **Ticks outside the sampling points** only advance `s`.
- **`s_tick` held low:** the FSM freezes in place, except the IDLE → START transition.

## Test plan
- **8N1, OVERSAMPLE = 16, byte 0x55:** `dout` = 0x55 and one `rx_done_tick`; `parity_err`, `frame_err` and `break_det` all 0.
- **8E1, 0xA3 with the parity bit forced to 1** (correct value is 0): `dout` = 0xA3, `parity_err` = 1, `frame_err` = 0.
- **8N1, 0x3C with the stop bit low**, followed by the line returning high: `dout` = 0x3C, `frame_err` = 1, `break_det` = 0.
- **Start-bit glitch, low for 4 ticks then high:** no `rx_done_tick`; `busy` returns to 0 within H+2 ticks; a following 0x81 frame is received correctly.
- **Line held low for 12 bit times:** first completion has `dout` = 0, `frame_err` = 1, `break_det` = 1.
- **DBIT = 7, odd parity, STOP_BITS = 2, back-to-back 0x7F, 0x00, 0x2A with a single-tick spike mid-bit in each:** three pulses with the correct data and no errors; a `reset` pulse mid-way through a 4th frame gives no pulse, and all outputs return to 0.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, 3-sample majority voting,
// optional parity, 1/2 stop bits, with parity/framing/break status per received word.
module uart_rx_param #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            busy,
  output logic [2:0]      dbg_state
);

  localparam int H  = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_SMP0  = SW'(H - 1);
  localparam logic [SW-1:0] S_SMP1  = SW'(H);
  localparam logic [SW-1:0] S_DEC   = SW'(H + 1);
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_SLAST = NW'(STOP_BITS - 1);
  localparam logic          HAS_PAR = (PARITY_EN != 0);
  localparam logic          PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta, rx_s;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [1:0]      smp_q, smp_d;
  logic            psmp_q, psmp_d;
  logic            perr_q, perr_d;
  logic            stop_lo_q, stop_lo_d;
  logic            stop_hi_q, stop_hi_d;
  logic            done_d;
  logic            brk_d;
  logic            maj;
  logic            at_dec, at_last;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign at_dec  = (s_q == S_DEC);
  assign at_last = (s_q == S_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    smp_d     = smp_q;
    psmp_d    = psmp_q;
    perr_d    = perr_q;
    stop_lo_d = stop_lo_q;
    stop_hi_d = stop_hi_q;
    done_d    = 1'b0;
    if (state_q == IDLE) begin
      // Start detection needs no tick, so a low line after a break restarts at once.
      if (!rx_s) begin
        state_d   = START;
        s_d       = '0;
        n_d       = '0;
        b_d       = '0;
        psmp_d    = 1'b0;
        perr_d    = 1'b0;
        stop_lo_d = 1'b0;
        stop_hi_d = 1'b0;
      end
    end else if (s_tick) begin
      s_d = at_last ? '0 : s_q + 1'b1;
      if (s_q == S_SMP0) smp_d[0] = rx_s;
      if (s_q == S_SMP1) smp_d[1] = rx_s;
      case (state_q)
        START: begin
          if (at_dec && maj) state_d = IDLE;
          else if (at_last)  state_d = DATA;
        end
        DATA: begin
          if (at_dec) b_d = {maj, b_q[DBIT-1:1]};
          if (at_last) begin
            if (n_q == N_LAST) begin
              n_d     = '0;
              state_d = HAS_PAR ? PARITY : STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (at_dec) begin
            psmp_d = maj;
            perr_d = maj ^ (^b_q) ^ PAR_ODD;
          end
          if (at_last) state_d = STOP;
        end
        STOP: begin
          if (at_dec) begin
            stop_lo_d = stop_lo_q | ~maj;
            stop_hi_d = stop_hi_q | maj;
            if (n_q == N_SLAST) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else if (at_last) begin
            n_d = n_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign brk_d = (b_q == '0) & ~psmp_q & ~stop_hi_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      smp_q        <= '0;
      psmp_q       <= 1'b0;
      perr_q       <= 1'b0;
      stop_lo_q    <= 1'b0;
      stop_hi_q    <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      smp_q        <= smp_d;
      psmp_q       <= psmp_d;
      perr_q       <= perr_d;
      stop_lo_q    <= stop_lo_d;
      stop_hi_q    <= stop_hi_d;
      rx_done_tick <= done_d;
      if (done_d) begin
        dout       <= b_q;
        parity_err <= perr_q & HAS_PAR;
        frame_err  <= stop_lo_d;
        break_det  <= brk_d;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
